// File: rtl/cordic_rnd_sat_stage.sv
// -----------------------------------------------------------------------------
// cordic_rnd_sat_stage
//
// Purpose:
//   Takes the signed DIN_W-bit product from the CORDIC 12x12 multiplier
//   (Q2.22 for Q1.11 operands) and returns it to the DOUT_W-bit datapath
//   format. Rounding is round-half-up: add half an output LSB, shift right
//   arithmetically by FRAC_W, then clip to the signed DOUT_W range.
//   The stage is a 2-deep valid/ready pipeline that collapses bubbles, so a
//   stalled output still lets one more sample into the first stage.
//
// Ports:
//   ap_clk    in   clock, rising edge
//   ap_rst    in   synchronous active-high reset, flushes the pipe
//   din       in   signed product
//   din_vld   in   din valid
//   din_rdy   out  stage accepts din this cycle (combinational from dout_rdy)
//   dout      out  rounded, saturated result (registered)
//   dout_sat  out  dout was clipped, qualified by dout_vld (registered)
//   dout_vld  out  dout/dout_sat valid (registered)
//   dout_rdy  in   downstream accepts dout
//   sat_cnt   out  saturating count of clipped output transfers
//                  (present only when CORDIC_RND_SAT_CNT_EN is defined)
//
// Optional feature macro: CORDIC_RND_SAT_CNT_EN
// -----------------------------------------------------------------------------
module cordic_rnd_sat_stage #(
  parameter int DIN_W  = 24,
  parameter int FRAC_W = 11,
  parameter int DOUT_W = 12
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_sat,
  output logic              dout_vld,
  input  logic              dout_rdy
`ifdef CORDIC_RND_SAT_CNT_EN
  ,
  output logic [15:0]       sat_cnt
`endif
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam int SUM_W = DIN_W + 1;
  // Comparison width wide enough to hold both the shifted sum and the limits.
  localparam int CMP_W = ((SUM_W > DOUT_W) ? SUM_W : DOUT_W) + 1;

  localparam logic signed [SUM_W-1:0]  HALF     = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  localparam logic signed [DOUT_W-1:0] DOUT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DOUT_W-1:0] DOUT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};
  localparam logic signed [CMP_W-1:0]  MAX_E    = CMP_W'(DOUT_MAX);
  localparam logic signed [CMP_W-1:0]  MIN_E    = CMP_W'(DOUT_MIN);

  logic                    s1_vld_r;
  logic signed [SUM_W-1:0] s1_sum_r;
  logic signed [SUM_W-1:0] din_ext_s;
  logic                    ld1_s;
  logic                    ld2_s;

  // Shift out the fraction and clip; returns {sat, value}.
  function automatic logic [DOUT_W:0] rnd_sat(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] sh;
    logic signed [CMP_W-1:0] q;
    logic [DOUT_W:0]         res;
    sh = sum >>> FRAC_W;
    q  = CMP_W'(sh);
    if (q > MAX_E) begin
      res = {1'b1, DOUT_MAX};
    end else if (q < MIN_E) begin
      res = {1'b1, DOUT_MIN};
    end else begin
      res = {1'b0, DOUT_W'(q)};
    end
    return res;
  endfunction

  // Output stage advances when empty or being drained; stage 1 advances when
  // empty or when it can push into stage 2. This is what collapses bubbles.
  assign ld2_s     = !dout_vld || dout_rdy;
  assign ld1_s     = !s1_vld_r || ld2_s;
  assign din_rdy   = ld1_s;
  assign din_ext_s = {din[DIN_W-1], din};

  // Two pipeline stages: rounding add, then shift/saturate into the output.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_vld_r <= 1'b0;
      s1_sum_r <= '0;
      dout_vld <= 1'b0;
      dout     <= '0;
      dout_sat <= 1'b0;
    end else begin
      if (ld1_s) begin
        s1_vld_r <= din_vld;
        if (din_vld) begin
          s1_sum_r <= din_ext_s + HALF;
        end
      end
      if (ld2_s) begin
        dout_vld <= s1_vld_r;
        if (s1_vld_r) begin
          {dout_sat, dout} <= rnd_sat(s1_sum_r);
        end
      end
    end
  end

`ifdef CORDIC_RND_SAT_CNT_EN
  logic [15:0] sat_cnt_r;

  // Count clipped samples as they leave; sticks at all-ones instead of wrapping.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_cnt_r <= 16'h0000;
    end else if (dout_vld && dout_rdy && dout_sat && (sat_cnt_r != 16'hFFFF)) begin
      sat_cnt_r <= sat_cnt_r + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_r;
`endif

endmodule

// File: tb/tb_cordic_rnd_sat_stage.sv
// -----------------------------------------------------------------------------
// tb_cordic_rnd_sat_stage
//
// Self-checking bench for cordic_rnd_sat_stage: directed vector table,
// hand-written backpressure and reset sequences, and a randomized run checked
// against a queue-based reference model of a 2-deep in-order pipe.
// -----------------------------------------------------------------------------
module tb_cordic_rnd_sat_stage;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [23:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [11:0] dout;
  logic        dout_sat;
  logic        dout_vld;
  logic        dout_rdy;
`ifdef CORDIC_RND_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  cordic_rnd_sat_stage dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .dout_sat (dout_sat),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
`ifdef CORDIC_RND_SAT_CNT_EN
    ,
    .sat_cnt  (sat_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [23:0] d;
    int          acc;
  } ent_t;

  typedef struct {
    int din;
    int q;
    bit sat;
  } vec_t;

  ent_t   mq[$];
  longint obs[$];
  int     nerr = 0;
  int     nchk = 0;
  int     cyc  = 0;
  int     nin  = 0;
  int     nout = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Real-number meaning: floor(x / 2^11 + 0.5), then clip to [-2048, 2047].
  function automatic void ref_rs(input logic [23:0] d, output longint q, output bit sat);
    longint x;
    x = longint'($signed(d)) + 64'sd1024;
    q = x / 2048;
    if ((x % 2048 != 0) && (x < 0)) q = q - 1;
    sat = 1'b0;
    if (q > 2047) begin
      q = 2047;
      sat = 1'b1;
    end else if (q < -2048) begin
      q = -2048;
      sat = 1'b1;
    end
  endfunction

  // One clock cycle, entered and left at the falling edge. The model is an
  // in-order queue of at most two samples: a sample shows at the output two
  // edges after its acceptance edge, and room exists unless two are held and
  // the output is stalled.
  task automatic step(input bit v, input int d, input bit r,
                      output bit acc, output bit popd, output longint pv);
    bit     exp_vld;
    bit     exp_rdy;
    longint q;
    bit     s;
    exp_vld = (mq.size() > 0) && (cyc >= mq[0].acc + 2);
    chk("dout_vld", dout_vld, exp_vld);
    pv = $signed(dout);
    if (exp_vld) begin
      ref_rs(mq[0].d, q, s);
      chk("dout", $signed(dout), q);
      chk("dout_sat", dout_sat, s);
    end
    din_vld  = v;
    din      = d[23:0];
    dout_rdy = r;
    #1;
    exp_rdy = (mq.size() < 2) || r;
    chk("din_rdy", din_rdy, exp_rdy);
    popd = exp_vld && r;
    acc  = v && exp_rdy;
    if (popd) begin
      void'(mq.pop_front());
      nout++;
    end
    if (acc) begin
      mq.push_back('{d[23:0], cyc});
      nin++;
    end
    @(posedge ap_clk);
    cyc++;
    @(negedge ap_clk);
  endtask

  task automatic idle(input int n);
    bit a, p;
    longint pv;
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1, a, p, pv);
  endtask

  task automatic do_reset();
    ap_rst   = 1'b1;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    @(posedge ap_clk);
    cyc++;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    mq.delete();
    #1;
    chk("rst dout_vld", dout_vld, 0);
    chk("rst dout", dout, 0);
    chk("rst dout_sat", dout_sat, 0);
    chk("rst din_rdy", din_rdy, 1);
  endtask

  function automatic int rand_din();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: rand_din = int'($urandom() & 32'h00FF_FFFF);
      1: rand_din = 4193280 + $urandom_range(0, 4096) - 2048;
      2: rand_din = -4195328 + $urandom_range(0, 4096) - 2048;
      default: rand_din = $urandom_range(0, 6000) - 3000;
    endcase
  endfunction

  initial begin
    vec_t   tv[12];
    bit     a, p;
    longint pv;
    int     idx;
    int     nacc;
    int     cur_d;
    bit     cur_v;

    tv[0]  = '{1024, 1, 1'b0};
    tv[1]  = '{1023, 0, 1'b0};
    tv[2]  = '{-1024, 0, 1'b0};
    tv[3]  = '{-1025, -1, 1'b0};
    tv[4]  = '{4192256, 2047, 1'b0};
    tv[5]  = '{8388607, 2047, 1'b1};
    tv[6]  = '{-8388608, -2048, 1'b1};
    tv[7]  = '{-4194304, -2048, 1'b0};
    tv[8]  = '{4193279, 2047, 1'b0};
    tv[9]  = '{4193280, 2047, 1'b1};
    tv[10] = '{-4195328, -2048, 1'b0};
    tv[11] = '{-4195329, -2048, 1'b1};

    ap_rst   = 1'b1;
    din      = 24'd0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    @(negedge ap_clk);
    do_reset();

    // Directed table: one sample at a time, output must be visible 2 cycles on.
    foreach (tv[i]) begin
      step(1'b1, tv[i].din, 1'b1, a, p, pv);
      chk("tbl accept", a, 1);
      step(1'b0, 0, 1'b1, a, p, pv);
      chk("tbl vld", dout_vld, 1);
      chk("tbl dout", $signed(dout), tv[i].q);
      chk("tbl sat", dout_sat, tv[i].sat);
      step(1'b0, 0, 1'b1, a, p, pv);
    end

    // Backpressure: only two samples fit while the output is stalled.
    idx  = 1;
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, idx * 2048, 1'b0, a, p, pv);
      if (a) begin
        idx++;
        nacc++;
      end
    end
    chk("bp accepted", nacc, 2);
    chk("bp held dout", $signed(dout), 1);
    obs.delete();
    for (int c = 0; c < 40 && obs.size() < 5; c++) begin
      step(idx <= 5, idx * 2048, 1'b1, a, p, pv);
      if (a) idx++;
      if (p) obs.push_back(pv);
    end
    chk("bp count", obs.size(), 5);
    for (int i = 0; i < obs.size(); i++) chk("bp order", obs[i], i + 1);

    // Reset with two entries in flight; they must never reappear.
    step(1'b1, 7 * 2048, 1'b0, a, p, pv);
    step(1'b1, 9 * 2048, 1'b0, a, p, pv);
    chk("fill both", mq.size(), 2);
    do_reset();
    idle(4);

    // Random traffic; upstream holds each sample until it is taken.
    nin   = 0;
    nout  = 0;
    cur_v = 1'b0;
    cur_d = 0;
    for (int c = 0; c < 40000 && nin < 10000; c++) begin
      if (!cur_v && ($urandom_range(0, 3) != 0)) begin
        cur_v = 1'b1;
        cur_d = rand_din();
      end
      step(cur_v, cur_d, $urandom_range(0, 3) != 0, a, p, pv);
      if (a) cur_v = 1'b0;
    end
    idle(5);
    chk("rand in count", nin, 10000);
    chk("rand in==out", nout, nin);

`ifdef CORDIC_RND_SAT_CNT_EN
    do_reset();
    chk("cnt reset", sat_cnt, 0);
    step(1'b1, 8388607, 1'b1, a, p, pv);
    step(1'b1, 2048, 1'b1, a, p, pv);
    step(1'b1, -8388608, 1'b1, a, p, pv);
    step(1'b1, 4096, 1'b1, a, p, pv);
    step(1'b1, 4193280, 1'b1, a, p, pv);
    idle(4);
    chk("sat_cnt 3", sat_cnt, 3);
    do_reset();
    din_vld  = 1'b1;
    din      = 24'h7FFFFF;
    dout_rdy = 1'b1;
    for (int i = 0; i < 65540; i++) @(negedge ap_clk);
    din_vld = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge ap_clk);
    chk("sat_cnt max", sat_cnt, 16'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
